sc_conv_sched: RTL and testbench

SC_CONV_SCHED -- requirements
Module: sc_conv_sched

---
 rtl/sc_conv_sched.sv | 155 +++++++++++++++
 tb/tb_sc_conv_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_conv_sched.sv
// Round-robin scheduler that shares one screen-to-world converter among N_REQ requesters.
// Optional build macro SC_SCHED_CLAMP_EN saturates captured coordinates to the screen bounds.
module sc_conv_sched #(
    parameter int N_REQ    = 4,
    parameter int WC_W     = 12,
    parameter int FRAC     = 10,
    parameter int CONV_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [11*N_REQ-1:0]      req_x,
    input  logic [11*N_REQ-1:0]      req_y,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [10:0]              res_y,
    output logic [10:0]              conv_x,
    output logic [10:0]              conv_y,
    output logic [10:0]              conv_res_y,
    input  logic [WC_W-1:0]          conv_x_wc,
    input  logic [WC_W-1:0]          conv_y_wc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WC_W-1:0]          rsp_x_wc,
    output logic [WC_W-1:0]          rsp_y_wc
);
    localparam int ID_W = $clog2(N_REQ);

    // FRAC only describes the converter's result format; reject configurations it cannot represent.
    generate
        if (N_REQ < 2 || N_REQ > 8 || CONV_LAT < 1 || CONV_LAT > 4 || FRAC > WC_W) begin : g_bad_cfg
            $error("sc_conv_sched: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic            grant_found;
    logic            grant_en;
    logic            conv_done;
    logic            rsp_done;
    logic [2:0]      cnt;
    logic [10:0]     sel_x, sel_y;
    logic [10:0]     cap_x, cap_y;

    // First requester at or above rr_ptr, wrapping past N_REQ-1 back to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_x = req_x[11*i +: 11];
                sel_y = req_y[11*i +: 11];
            end
        end
    end

    always_comb begin
        cap_x = sel_x;
        cap_y = sel_y;
`ifdef SC_SCHED_CLAMP_EN
        if (sel_x > 11'd1279)
            cap_x = 11'd1279;
        if (sel_y >= res_y)
            cap_y = (res_y == '0) ? '0 : res_y - 11'd1;
`endif
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        conv_done = 1'b0;
        rsp_done  = 1'b0;
        unique case (state)
            IDLE: if (grant_found) begin
                grant_en  = 1'b1;
                state_nxt = CONV;
            end
            CONV: if (cnt == 3'(CONV_LAT-1)) begin
                conv_done = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            req_ready[i] = rst_n && grant_en && (grant_idx == ID_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_x_wc   <= '0;
            rsp_y_wc   <= '0;
            conv_x     <= '0;
            conv_y     <= '0;
            conv_res_y <= '0;
        end else begin
            if (grant_en) begin
                conv_x     <= cap_x;
                conv_y     <= cap_y;
                conv_res_y <= res_y;
                rsp_id     <= grant_idx;
            end
            if (state == CONV)
                cnt <= conv_done ? '0 : cnt + 3'd1;
            if (conv_done) begin
                rsp_x_wc  <= conv_x_wc;
                rsp_y_wc  <= conv_y_wc;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (rsp_id == ID_W'(N_REQ-1)) ? '0 : rsp_id + ID_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sc_conv_sched.sv
// Directed bench for sc_conv_sched (N_REQ=4, CONV_LAT=1) with a behavioural converter model.
// Expected clamp results follow SC_SCHED_CLAMP_EN when the bench is built with it.
module tb_sc_conv_sched;
    localparam int N_REQ = 4;
    localparam int WC_W  = 12;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [11*N_REQ-1:0] req_x, req_y;
    logic [N_REQ-1:0]   req_ready;
    logic [10:0]        res_y;
    logic [10:0]        conv_x, conv_y, conv_res_y;
    logic [WC_W-1:0]    conv_x_wc, conv_y_wc;
    logic               rsp_valid, rsp_ready;
    logic [1:0]         rsp_id;
    logic [WC_W-1:0]    rsp_x_wc, rsp_y_wc;

    logic [10:0] sx [N_REQ];
    logic [10:0] sy [N_REQ];

    int n_checks = 0;
    int n_fail   = 0;

    sc_conv_sched #(
        .N_REQ   (N_REQ),
        .WC_W    (WC_W),
        .FRAC    (10),
        .CONV_LAT(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_y     (res_y),
        .conv_x    (conv_x),
        .conv_y    (conv_y),
        .conv_res_y(conv_res_y),
        .conv_x_wc (conv_x_wc),
        .conv_y_wc (conv_y_wc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x_wc  (rsp_x_wc),
        .rsp_y_wc  (rsp_y_wc)
    );

    always #5 clk = ~clk;

    // Converter model: x+1, y+2; with CONV_LAT=1 the result is sampled in the same cycle the operands appear.
    assign conv_x_wc = WC_W'(conv_x) + 12'd1;
    assign conv_y_wc = WC_W'(conv_y) + 12'd2;

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_x[11*i +: 11] = sx[i];
            req_y[11*i +: 11] = sy[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full transaction: grant in cycle T, response in T+2, handshake at end of T+2.
    task automatic serve(input logic [3:0] rv, input int idx, input logic [11:0] ex,
                         input logic [11:0] ey, input bit drop);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        req_valid = rv;
        rsp_ready = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(onehot));
        step();
        if (drop) req_valid = '0;
        #1;
        check("ready_in_conv", 32'(req_ready), 32'd0);
        check("rsp_valid_early", 32'(rsp_valid), 32'd0);
        step();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("ready_in_resp", 32'(req_ready), 32'd0);
        check("rsp_id", 32'(rsp_id), 32'(idx));
        check("rsp_x_wc", 32'(rsp_x_wc), 32'(ex));
        check("rsp_y_wc", 32'(rsp_y_wc), 32'(ey));
        step();
        check("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        sx[0] = 11'd100; sy[0] = 11'd200;
        sx[1] = 11'd300; sy[1] = 11'd210;
        sx[2] = 11'd500; sy[2] = 11'd220;
        sx[3] = 11'd700; sy[3] = 11'd230;
        res_y     = 11'd480;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_x", 32'(rsp_x_wc), 32'd0);
        check("rst_conv_x", 32'(conv_x), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Single request with exact latency, dropping req_valid after the grant.
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("t1_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        check("t1_conv_x", 32'(conv_x), 32'd100);
        check("t1_conv_y", 32'(conv_y), 32'd200);
        check("t1_conv_res_y", 32'(conv_res_y), 32'd480);
        check("t1_rsp_valid_T1", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_valid_T2", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_x", 32'(rsp_x_wc), 32'd101);
        check("t1_rsp_y", 32'(rsp_y_wc), 32'd202);
        step();
        check("t1_rsp_clear", 32'(rsp_valid), 32'd0);

        // Idle with no requests: everything holds.
        repeat (3) step();
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_conv_x", 32'(conv_x), 32'd100);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // Reset pulse brings rr_ptr back to 0.
        rst_n = 1'b0;
        #1;
        check("pulse_conv_x", 32'(conv_x), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // All requesting: order 0,1,2,3,0.
        serve(4'b1111, 0, 12'd101, 12'd202, 1'b0);
        serve(4'b1111, 1, 12'd301, 12'd212, 1'b0);
        serve(4'b1111, 2, 12'd501, 12'd222, 1'b0);
        serve(4'b1111, 3, 12'd701, 12'd232, 1'b0);
        serve(4'b1111, 0, 12'd101, 12'd202, 1'b1);

        // rr_ptr=1: serve 2, leaving rr_ptr=3.
        serve(4'b0100, 2, 12'd501, 12'd222, 1'b1);

        // Wrap to index 0, then stall the response for 5 cycles with everyone requesting.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("wrap_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_id", 32'(rsp_id), 32'd0);
            check("stall_rsp_x", 32'(rsp_x_wc), 32'd101);
            check("stall_rsp_y", 32'(rsp_y_wc), 32'd202);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("stall_rsp_clear", 32'(rsp_valid), 32'd0);
        check("after_stall_grant", 32'(req_ready), 32'b0010);
        req_valid = '0;
        #1;
        check("after_stall_nogrant", 32'(req_ready), 32'd0);
        step();

        // Reset one cycle after a grant aborts the transaction.
        req_valid = 4'b1000;
        #1;
        check("abort_grant", 32'(req_ready), 32'b1000);
        step();
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_conv_x", 32'(conv_x), 32'd0);
        check("abort_conv_y", 32'(conv_y), 32'd0);
        check("abort_conv_res_y", 32'(conv_res_y), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_x", 32'(rsp_x_wc), 32'd0);
        step();
        check("abort_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        serve(4'b0100, 2, 12'd501, 12'd222, 1'b1);

        // Out-of-range coordinates: clamped when the macro is defined, passed through otherwise.
        sx[1] = 11'd1500;
        sy[1] = 11'd900;
        res_y = 11'd800;
`ifdef SC_SCHED_CLAMP_EN
        serve(4'b0010, 1, 12'd1280, 12'd801, 1'b1);
`else
        serve(4'b0010, 1, 12'd1501, 12'd902, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
